spi_monarch_16: RTL and testbench

- 16-bit SPI master that sits directly upstream of the A2D round-robin interface and carries every ADC128S transaction: command word out on MOSI, conversion result in on MISO.
- The A2D interface pulses wrt with a command, waits for done, then takes rd_data.
- Fixed SPI mode: SCLK idles high, MISO is sampled on SCLK rise, MOSI shifts on SCLK fall, MSB first.

---
 rtl/spi_monarch_16.sv | 108 ++++++++++
 tb/tb_spi_monarch_16.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_monarch_16.sv
// SPI master for the ADC128S path: SCLK idles high, MISO sampled on SCLK rise,
// MOSI shifted on SCLK fall, MSB first, fixed DATA_W-bit transactions.
module spi_monarch_16 #(
    parameter int unsigned DIV_W  = 5,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [DATA_W-1:0] wt_data,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              SS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] IDLE_DIV = {1'b1, 1'b0, {(DIV_W-2){1'b1}}};
    localparam logic [DIV_W-1:0] RISE_DIV = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] FALL_DIV = '1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DATA_W-1:0]   shft_q, shft_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                smpl_q, smpl_d;
    logic                ss_n_q, ss_n_d;
    logic                done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= IDLE_DIV;
            shft_q  <= '0;
            cnt_q   <= '0;
            smpl_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            shft_q  <= shft_d;
            cnt_q   <= cnt_d;
            smpl_q  <= smpl_d;
            ss_n_q  <= ss_n_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        shft_d  = shft_q;
        cnt_d   = cnt_q;
        smpl_d  = smpl_q;
        ss_n_d  = ss_n_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                div_d = IDLE_DIV;
                if (wrt) begin
                    // The accept edge already counts as the first divider step.
                    div_d   = IDLE_DIV + 1'b1;
                    shft_d  = wt_data;
                    cnt_d   = '0;
                    ss_n_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_q == RISE_DIV) begin
                    smpl_d = MISO;
                    cnt_d  = cnt_q + 1'b1;
                end
                if (div_q == FALL_DIV) begin
                    if (cnt_q == LAST_CNT) begin
                        shft_d  = {shft_q[DATA_W-2:0], smpl_q};
                        div_d   = IDLE_DIV;
                        ss_n_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (cnt_q != '0) begin
                        shft_d = {shft_q[DATA_W-2:0], smpl_q};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign SCLK    = div_q[DIV_W-1];
    assign SS_n    = ss_n_q;
    assign done    = done_q;
    assign rd_data = shft_q;
    assign MOSI    = shft_q[DATA_W-1];

endmodule

// File: tb/tb_spi_monarch_16.sv
// Directed bench for spi_monarch_16: reset, loopback, constant MISO, busy write,
// mid-transfer reset and back-to-back transactions with edge-exact timing.
`timescale 1ns/1ps
module tb_spi_monarch_16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrt = 1'b0;
    logic [15:0] wt_data = '0;
    logic        done;
    logic [15:0] rd_data;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        loop_en = 1'b1;
    logic        miso_c  = 1'b0;

    int tests = 0;
    int fails = 0;
    int cur   = 0;

    logic sclk_h [0:599];
    logic mosi_h [0:599];
    logic ssn_h  [0:599];
    logic done_h [0:599];

    always #5 clk = ~clk;

    assign MISO = loop_en ? MOSI : miso_c;

    spi_monarch_16 #(.DIV_W(5), .DATA_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .wt_data (wt_data),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic record(input int idx);
        sclk_h[idx] = SCLK;
        mosi_h[idx] = MOSI;
        ssn_h[idx]  = SS_n;
        done_h[idx] = done;
    endtask

    // Edge 0 is the edge that samples wrt.
    task automatic start(input logic [15:0] d);
        wrt     = 1'b1;
        wt_data = d;
        @(posedge clk);
        #1;
        wrt = 1'b0;
        cur = 0;
        record(0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cur++;
            record(cur);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xfer_checks(input string nm, input logic [15:0] exp_rd, input logic exp_mosi0);
        int rises, last_rise, first_fall, viol, ssn_hi;
        rises = 0; last_rise = -1; first_fall = -1; viol = 0; ssn_hi = 0;
        for (int k = 1; k <= 520; k++) begin
            if (!sclk_h[k-1] && sclk_h[k]) begin
                if (!ssn_h[k-1]) rises++;
                last_rise = k;
                if (k >= 2 && k < 520) begin
                    if (mosi_h[k-2] !== mosi_h[k-1] || mosi_h[k] !== mosi_h[k-1] ||
                        mosi_h[k+1] !== mosi_h[k])
                        viol++;
                end
            end
            if (sclk_h[k-1] && !sclk_h[k] && first_fall < 0) first_fall = k;
        end
        for (int k = 0; k < 520; k++) if (ssn_h[k] !== 1'b0) ssn_hi++;
        chk({nm, "_mosi0"}, 32'(mosi_h[0]), 32'(exp_mosi0));
        chk({nm, "_ssn_low"}, ssn_hi, 0);
        chk({nm, "_ssn520"}, 32'(ssn_h[520]), 1);
        chk({nm, "_done519"}, 32'(done_h[519]), 0);
        chk({nm, "_done520"}, 32'(done_h[520]), 1);
        chk({nm, "_rises"}, rises, 16);
        chk({nm, "_last_rise"}, last_rise, 504);
        chk({nm, "_first_fall"}, first_fall, 8);
        chk({nm, "_mosi_stable"}, viol, 0);
        chk({nm, "_sclk520"}, 32'(sclk_h[520]), 1);
        chk({nm, "_rd"}, 32'(rd_data), 32'(exp_rd));
    endtask

    initial begin
        int dn;

        // 1. Reset with wrt asserted
        rst = 1'b1;
        wrt = 1'b1;
        wt_data = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_ssn", 32'(SS_n), 1);
            chk("rst_sclk", 32'(SCLK), 1);
            chk("rst_done", 32'(done), 0);
            chk("rst_mosi", 32'(MOSI), 0);
            chk("rst_rd", 32'(rd_data), 32'h0000);
        end
        rst = 1'b0;
        wrt = 1'b0;
        idle(3);
        chk("idle_ssn", 32'(SS_n), 1);

        // 2. Loopback
        loop_en = 1'b1;
        start(16'hA5C3);
        run(520);
        xfer_checks("loop_a5c3", 16'hA5C3, 1'b1);
        idle(4);
        chk("idle_done_level", 32'(done), 1);

        // 3. Constant MISO
        loop_en = 1'b0;
        miso_c  = 1'b1;
        start(16'h0000);
        run(520);
        xfer_checks("miso1", 16'hFFFF, 1'b0);
        idle(3);
        miso_c = 1'b0;
        start(16'hFFFF);
        run(520);
        xfer_checks("miso0", 16'h0000, 1'b1);
        idle(3);

        // 4. Busy write ignored
        loop_en = 1'b1;
        start(16'h8001);
        run(99);
        wrt     = 1'b1;
        wt_data = 16'h1234;
        run(1);
        wrt = 1'b0;
        run(420);
        xfer_checks("busy", 16'h8001, 1'b1);
        idle(3);

        // 5. Mid-transfer reset
        start(16'hAAAA);
        run(199);
        rst = 1'b1;
        run(1);
        chk("abort_ssn", 32'(SS_n), 1);
        chk("abort_sclk", 32'(SCLK), 1);
        chk("abort_done", 32'(done), 0);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || SS_n !== 1'b1) dn++;
        end
        chk("abort_quiet", dn, 0);
        start(16'h0F0F);
        run(520);
        xfer_checks("after_abort", 16'h0F0F, 1'b0);

        // 6. Back-to-back in the first done cycle
        start(16'h3C5A);
        chk("b2b_ssn0", 32'(SS_n), 0);
        chk("b2b_done0", 32'(done), 0);
        run(520);
        xfer_checks("b2b", 16'h3C5A, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
